alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 132 +++++++++++++
 tb/tb_alu_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, carry/zero flags and iterative shifts.
// Optional build macro ALU_SIGNED_CMP_EN: CMP compares operands as two's-complement signed.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_SHR = 3'b010,
    OP_SHL = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_CMP = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  state_e           state, state_d;
  op_e              op;
  logic [WIDTH-1:0] work, work_d, z_d;
  logic [SHW-1:0]   cnt, cnt_d, amt;
  logic             shl, shl_d, carry_d, zero_d;
  logic [WIDTH:0]   sum, diff;
  logic             gt, lt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign op        = op_e'(s);
  assign amt       = y[SHW-1:0];
  assign sum       = {1'b0, x} + {1'b0, y};
  assign diff      = {1'b0, x} - {1'b0, y};

`ifdef ALU_SIGNED_CMP_EN
  assign gt = $signed(x) > $signed(y);
  assign lt = $signed(x) < $signed(y);
`else
  assign gt = x > y;
  assign lt = x < y;
`endif

  always_comb begin
    state_d = state;
    work_d  = work;
    cnt_d   = cnt;
    shl_d   = shl;
    z_d     = z;
    carry_d = carry;
    zero_d  = zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          carry_d = 1'b0;
          case (op)
            OP_AND: z_d = x & y;
            OP_OR:  z_d = x | y;
            OP_SHR, OP_SHL: begin
              // z is only written when the shift finishes; a zero-amount shift passes x through
              if (amt != '0) begin
                state_d = SHIFT;
                work_d  = x;
                cnt_d   = amt;
                shl_d   = (op == OP_SHL);
              end else begin
                z_d = x;
              end
            end
            OP_ADD: {carry_d, z_d} = sum;
            OP_SUB: {carry_d, z_d} = diff;
            OP_CMP: z_d = gt ? WIDTH'(1) : (lt ? WIDTH'(2) : '0);
            default: z_d = '0;
          endcase
          if (state_d == DONE) zero_d = (z_d == '0);
        end
      end
      SHIFT: begin
        if (shl) begin
          work_d  = work << 1;
          carry_d = work[WIDTH-1];
        end else begin
          work_d  = work >> 1;
          carry_d = work[0];
        end
        cnt_d = cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          z_d     = work_d;
          zero_d  = (work_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      shl   <= 1'b0;
      z     <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_d;
      work  <= work_d;
      cnt   <= cnt_d;
      shl   <= shl_d;
      z     <= z_d;
      carry <= carry_d;
      zero  <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver queues model results, a monitor checks each handshake.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   s = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] z;
  logic         carry;
  logic         zero;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  typedef struct {
    logic [W-1:0] z;
    logic         c;
    logic         zf;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Reference behaviour from the opcode table; lat = extra cycles spent shifting.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    exp_t e;
    int ua, ub, sa, sb, n, r;
    ua = int'(a);
    ub = int'(b);
    n  = ub % W;
    r  = 0;
    e.c = 1'b0;
    e.lat = 0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: begin
        r = ua >> n;
        if (n > 0) e.c = ((ua >> (n - 1)) & 1) != 0;
        e.lat = n;
      end
      3'd3: begin
        r = (ua << n) % (1 << W);
        if (n > 0) e.c = ((ua >> (W - n)) & 1) != 0;
        e.lat = n;
      end
      3'd4: begin
        r = (ua + ub) % (1 << W);
        e.c = (ua + ub) >= (1 << W);
      end
      3'd5: begin
        r = (ua - ub + (1 << W)) % (1 << W);
        e.c = ua < ub;
      end
      3'd6: begin
`ifdef ALU_SIGNED_CMP_EN
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
`else
        sa = ua;
        sb = ub;
`endif
        r = (sa > sb) ? 1 : ((sa < sb) ? 2 : 0);
      end
      default: r = 0;
    endcase
    e.z  = W'(r);
    e.zf = (r == 0);
    return e;
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  initial begin : monitor
    int   cyc;
    int   acc_cyc;
    logic prev_ov;
    exp_t e;
    cyc = 0;
    acc_cyc = -1;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        acc_cyc = -1;
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov && exp_q.size() != 0)
          check("latency", cyc - acc_cyc - 1, exp_q[0].lat);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=z%0h required=none at %0t", z, $time);
          end else begin
            e = exp_q.pop_front();
            check("z", z, e.z);
            check("carry", carry, e.c);
            check("zero", zero, e.zf);
          end
        end
        if (in_valid && in_ready) acc_cyc = cyc;
        prev_ov = out_valid;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    x = a;
    y = b;
    s = op;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 1000);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready0 required=in_ready1 at %0t", $time);
    end else begin
      exp_q.push_back(model(a, b, op));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
    s = 3'($urandom);
  endtask

  // Waits for all queued results; the block must refuse new work while one is outstanding.
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
      if (exp_q.size() != 0) check("busy_in_ready", in_ready, 1'b0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 at %0t", exp_q.size(), $time);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t eb;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", z, 8'h00);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    issue(8'hF0, 8'h20, 3'd4);
    drain();
    @(negedge clk);
    #1;
    check("ready_after_hs", in_ready, 1'b1);

    issue(8'h05, 8'h05, 3'd5);
    issue(8'h03, 8'h05, 3'd5);
    issue(8'h81, 8'h03, 3'd3);
    drain();
    issue(8'h81, 8'h00, 3'd2);
    issue(8'h80, 8'h7F, 3'd6);
    issue(8'h33, 8'h33, 3'd6);
    issue(8'h5A, 8'hF8, 3'd2);  // amount from y[2:0] only: shift by 0
    issue(8'hA5, 8'h0F, 3'd7);
    drain();

    ready_mode = 2;
    @(posedge clk);
    issue(8'hC8, 8'h64, 3'd4);
    eb = model(8'hC8, 8'h64, 3'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      x = W'($urandom);
      y = W'($urandom);
      s = 3'($urandom);
      @(negedge clk);
      check("bp_z", z, eb.z);
      check("bp_carry", carry, eb.c);
      check("bp_zero", zero, eb.zf);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_mode = 0;
    drain();
    issue(8'h0F, 8'h30, 3'd1);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 150; i++)
      issue(W'($urandom), W'($urandom), 3'($urandom));
    drain();
    ready_mode = 0;

    issue(8'h0F, 8'h30, 3'd1);
    drain();
    issue(8'hFF, 8'h07, 3'd2);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_z", z, 8'h00);
    check("midrst_carry", carry, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(8'hF0, 8'h3C, 3'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
